// File: rtl/ex_muldiv_pkg.sv
// Shared ALU opcode encodings and multiply/divide FSM state type for the EX-stage mul/div unit.
package ex_muldiv_pkg;

    localparam logic [4:0] ALU_NOP   = 5'd0;
    localparam logic [4:0] ALU_MULT  = 5'd20;
    localparam logic [4:0] ALU_MULTU = 5'd21;
    localparam logic [4:0] ALU_DIV   = 5'd22;
    localparam logic [4:0] ALU_DIVU  = 5'd23;
    localparam logic [4:0] ALU_MFHI  = 5'd24;
    localparam logic [4:0] ALU_MFLO  = 5'd25;
    localparam logic [4:0] ALU_MTHI  = 5'd26;
    localparam logic [4:0] ALU_MTLO  = 5'd27;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/ex_muldiv_core.sv
// Radix-2 datapath: shift-add multiply / restoring divide on unsigned magnitudes.
// o_hi/o_lo are the accumulator values after the step taken this cycle.
module muldiv_core
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_div,
    input  logic [XLEN-1:0] i_opa,
    input  logic [XLEN-1:0] i_opb,
    output logic            o_last,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN-1:0]  r_acc_hi;
    logic [XLEN-1:0]  r_acc_lo;
    logic [XLEN-1:0]  r_opb;
    logic             r_div;
    logic [CNT_W-1:0] r_count;

    logic [XLEN-1:0] w_add;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_sub;

    assign w_add   = r_acc_lo[0] ? r_opb : '0;
    assign w_sum   = {1'b0, r_acc_hi} + {1'b0, w_add};
    assign w_shift = {r_acc_hi, r_acc_lo[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, r_opb});
    // Remainder stays below the divisor, so the XLEN-bit difference never loses bits.
    assign w_sub   = w_shift[XLEN-1:0] - r_opb;

    always_comb begin
        o_hi = r_acc_hi;
        o_lo = r_acc_lo;
        if (r_div) begin
            o_hi = w_ge ? w_sub : w_shift[XLEN-1:0];
            o_lo = {r_acc_lo[XLEN-2:0], w_ge};
        end else begin
            o_hi = w_sum[XLEN:1];
            o_lo = {w_sum[0], r_acc_lo[XLEN-1:1]};
        end
    end

    assign o_last = (r_count == CNT_W'(XLEN - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_opb    <= '0;
            r_div    <= 1'b0;
            r_count  <= '0;
        end else if (i_load) begin
            r_acc_hi <= '0;
            r_acc_lo <= i_opa;
            r_opb    <= i_opb;
            r_div    <= i_div;
            r_count  <= '0;
        end else if (i_step) begin
            r_acc_hi <= o_hi;
            r_acc_lo <= o_lo;
            r_count  <= o_last ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit owning HI/LO; stalls the pipeline during iterative ops.
// Optional: define MULDIV_FAST_MUL_EN for single-cycle MULT/MULTU.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      id_ex_alu_op,
    input  logic [XLEN-1:0] id_ex_gpr_rs,
    input  logic [XLEN-1:0] id_ex_gpr_rt,
    output logic            md_stall,
    output logic [XLEN-1:0] md_hi,
    output logic [XLEN-1:0] md_lo,
    output logic [XLEN-1:0] md_result,
    output logic            md_result_valid
);

    md_state_e       r_state;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic            r_is_div;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_div0;

    logic              w_is_mul, w_is_div, w_signed, w_iter, w_start;
    logic              w_neg_q, w_load, w_last;
    logic [XLEN-1:0]   w_a_mag, w_b_mag, w_core_hi, w_core_lo, w_quo, w_rem;
    logic [2*XLEN-1:0] w_prod, w_prod_fix;

    assign w_is_mul = (id_ex_alu_op == ALU_MULT) || (id_ex_alu_op == ALU_MULTU);
    assign w_is_div = (id_ex_alu_op == ALU_DIV)  || (id_ex_alu_op == ALU_DIVU);
    assign w_signed = (id_ex_alu_op == ALU_MULT) || (id_ex_alu_op == ALU_DIV);
    assign w_iter   = w_is_mul || w_is_div;
    assign w_neg_q  = w_signed && (id_ex_gpr_rs[XLEN-1] ^ id_ex_gpr_rt[XLEN-1]);
    assign w_a_mag  = (w_signed && id_ex_gpr_rs[XLEN-1]) ? -id_ex_gpr_rs : id_ex_gpr_rs;
    assign w_b_mag  = (w_signed && id_ex_gpr_rt[XLEN-1]) ? -id_ex_gpr_rt : id_ex_gpr_rt;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_raw, w_fast_fix;
    assign w_fast_raw = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
    assign w_fast_fix = w_neg_q ? -w_fast_raw : w_fast_raw;
    assign w_start    = w_is_div;
`else
    assign w_start    = w_iter;
`endif

    assign w_load = (r_state == MD_IDLE) && w_start;

    muldiv_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_step (r_state == MD_BUSY),
        .i_div  (w_is_div),
        .i_opa  (w_a_mag),
        .i_opb  (w_b_mag),
        .o_last (w_last),
        .o_hi   (w_core_hi),
        .o_lo   (w_core_lo)
    );

    assign w_prod     = {w_core_hi, w_core_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    // Divide-by-zero quotient is all ones regardless of operand signs.
    assign w_quo      = r_div0 ? '1 : (r_neg_q ? -w_core_lo : w_core_lo);
    assign w_rem      = r_neg_r ? -w_core_hi : w_core_hi;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= MD_IDLE;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (id_ex_alu_op == ALU_MTHI) r_hi <= id_ex_gpr_rs;
                    if (id_ex_alu_op == ALU_MTLO) r_lo <= id_ex_gpr_rs;
`ifdef MULDIV_FAST_MUL_EN
                    if (w_is_mul) begin
                        {r_hi, r_lo} <= w_fast_fix;
                        r_state      <= MD_DONE;
                    end
`endif
                    if (w_start) begin
                        r_is_div <= w_is_div;
                        r_neg_q  <= w_neg_q;
                        r_neg_r  <= w_signed && id_ex_gpr_rs[XLEN-1];
                        r_div0   <= (id_ex_gpr_rt == '0);
                        r_state  <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    if (w_last) begin
                        if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            {r_hi, r_lo} <= w_prod_fix;
                        end
                        r_state <= MD_DONE;
                    end
                end
                MD_DONE: r_state <= MD_IDLE;
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    // Gated by reset so the stall drops as soon as reset asserts, even with an op held.
    assign md_stall        = reset && w_iter && (r_state != MD_DONE);
    assign md_result_valid = reset && ((id_ex_alu_op == ALU_MFHI) || (id_ex_alu_op == ALU_MFLO));
    assign md_result       = (id_ex_alu_op == ALU_MFHI) ? r_hi :
                             (id_ex_alu_op == ALU_MFLO) ? r_lo : '0;
    assign md_hi           = r_hi;
    assign md_lo           = r_lo;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: scoreboard of expected HI/LO plus stall-length checks.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_ex_alu_op;
    logic [31:0] id_ex_gpr_rs, id_ex_gpr_rt;
    logic        md_stall, md_result_valid;
    logic [31:0] md_hi, md_lo, md_result;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sb_q[$];

    ex_muldiv #(.XLEN(32), .CNT_W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_ex_alu_op    (id_ex_alu_op),
        .id_ex_gpr_rs    (id_ex_gpr_rs),
        .id_ex_gpr_rt    (id_ex_gpr_rt),
        .md_stall        (md_stall),
        .md_hi           (md_hi),
        .md_lo           (md_lo),
        .md_result       (md_result),
        .md_result_valid (md_result_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] rs, input logic [31:0] rt);
        longint          sp;
        longint unsigned up;
        int              sq, sr;
        logic [63:0]     res;
        res = '0;
        case (op)
            ALU_MULT: begin
                sp  = longint'($signed(rs)) * longint'($signed(rt));
                res = sp;
            end
            ALU_MULTU: begin
                up  = {32'd0, rs} * {32'd0, rt};
                res = up;
            end
            ALU_DIV: begin
                if (rt == 32'd0) res = {rs, 32'hFFFF_FFFF};
                else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
                else begin
                    sq  = $signed(rs) / $signed(rt);
                    sr  = $signed(rs) % $signed(rt);
                    res = {sr, sq};
                end
            end
            ALU_DIVU: begin
                if (rt == 32'd0) res = {rs, 32'hFFFF_FFFF};
                else res = {rs % rt, rs / rt};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic int exp_stall(input logic [4:0] op);
`ifdef MULDIV_FAST_MUL_EN
        if (op == ALU_MULT || op == ALU_MULTU) return 1;
`endif
        return 33;
    endfunction

    // Drives one iterative op (caller is at a negedge) and returns at the DONE-cycle negedge.
    task automatic issue(input logic [4:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         output int stalls);
        id_ex_alu_op = op;
        id_ex_gpr_rs = rs;
        id_ex_gpr_rt = rt;
        sb_q.push_back(model(op, rs, rt));
        stalls = 0;
        #1;
        while (md_stall && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
    endtask

    task automatic run_and_check(input string name, input logic [4:0] op,
                                 input logic [31:0] rs, input logic [31:0] rt);
        int          st;
        logic [63:0] exp;
        issue(op, rs, rt, st);
        exp = sb_q.pop_front();
        n_tests++;
        if (st !== exp_stall(op)) begin
            n_fail++;
            $display("FAIL %s stall_cycles got %0d want %0d", name, st, exp_stall(op));
        end
        n_tests++;
        if ({md_hi, md_lo} !== exp) begin
            n_fail++;
            $display("FAIL %s hi_lo got %h_%h want %h_%h", name, md_hi, md_lo, exp[63:32], exp[31:0]);
        end
        @(negedge clk);
        id_ex_alu_op = ALU_NOP;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        id_ex_alu_op = ALU_MULT;
        id_ex_gpr_rs = 32'h1;
        id_ex_gpr_rt = 32'h1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (md_stall !== 1'b0 || md_result !== 32'd0 || md_result_valid !== 1'b0 ||
            md_hi !== 32'd0 || md_lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state got stall=%b res=%h vld=%b hi=%h lo=%h want all 0",
                     md_stall, md_result, md_result_valid, md_hi, md_lo);
        end
        id_ex_alu_op = ALU_NOP;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        run_and_check("mult_neg1x2",  ALU_MULT,  32'hFFFF_FFFF, 32'h2);
        run_and_check("multu_max_x2", ALU_MULTU, 32'hFFFF_FFFF, 32'h2);
        run_and_check("mult_negneg",  ALU_MULT,  32'h8000_0000, 32'h8000_0000);
    endtask

    task automatic test_div();
        run_and_check("div_neg7_2",    ALU_DIV,  32'hFFFF_FFF9, 32'h2);
        run_and_check("divu_100_7",    ALU_DIVU, 32'd100, 32'd7);
        run_and_check("divu_by_zero",  ALU_DIVU, 32'h1234, 32'h0);
        run_and_check("div_overflow",  ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
        run_and_check("div_neg_by_0",  ALU_DIV,  32'hFFFF_FF00, 32'h0);
        run_and_check("div_7_neg2",    ALU_DIV,  32'd7, 32'hFFFF_FFFE);
    endtask

    task automatic test_mt_mf();
        id_ex_alu_op = ALU_MTHI;
        id_ex_gpr_rs = 32'hAAAA_0000;
        #1;
        n_tests++;
        if (md_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi_stall got %b want 0", md_stall);
        end
        @(negedge clk);
        id_ex_alu_op = ALU_MFHI;
        id_ex_gpr_rs = 32'h0;
        #1;
        n_tests++;
        if (md_result !== 32'hAAAA_0000 || md_result_valid !== 1'b1 || md_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mfhi got res=%h vld=%b stall=%b want aaaa0000/1/0",
                     md_result, md_result_valid, md_stall);
        end
        @(negedge clk);
        id_ex_alu_op = ALU_MTLO;
        id_ex_gpr_rs = 32'h0000_5555;
        @(negedge clk);
        id_ex_alu_op = ALU_MFLO;
        #1;
        n_tests++;
        if (md_result !== 32'h0000_5555 || md_result_valid !== 1'b1 || md_hi !== 32'hAAAA_0000) begin
            n_fail++;
            $display("FAIL mflo got res=%h vld=%b hi=%h want 00005555/1/aaaa0000",
                     md_result, md_result_valid, md_hi);
        end
        @(negedge clk);
        id_ex_alu_op = ALU_NOP;
        #1;
        n_tests++;
        if (md_result !== 32'd0 || md_result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL nop_result got res=%h vld=%b want 0/0", md_result, md_result_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        int st;
        id_ex_alu_op = ALU_DIVU;
        id_ex_gpr_rs = 32'd100;
        id_ex_gpr_rt = 32'd7;
        repeat (11) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        n_tests++;
        if (md_stall !== 1'b0 || md_hi !== 32'd0 || md_lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_busy got stall=%b hi=%h lo=%h want 0/0/0", md_stall, md_hi, md_lo);
        end
        id_ex_alu_op = ALU_NOP;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_and_check("multu_after_rst", ALU_MULTU, 32'd3, 32'd5);
        st = 0;
    endtask

    task automatic test_back_to_back();
        int          st;
        logic [63:0] exp;
        logic [4:0]  ops [4] = '{ALU_MULT, ALU_DIV, ALU_MULTU, ALU_DIVU};
        for (int i = 0; i < 8; i++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            op = ops[$urandom_range(0, 3)];
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom >> $urandom_range(0, 28));
            issue(op, a, b, st);
            exp = sb_q.pop_front();
            n_tests++;
            if (st !== exp_stall(op) || {md_hi, md_lo} !== exp) begin
                n_fail++;
                $display("FAIL b2b_%0d op=%0d a=%h b=%h got st=%0d %h_%h want st=%0d %h_%h",
                         i, op, a, b, st, md_hi, md_lo, exp_stall(op), exp[63:32], exp[31:0]);
            end
            @(negedge clk);
        end
        id_ex_alu_op = ALU_NOP;
        @(negedge clk);
    endtask

`ifdef MULDIV_FAST_MUL_EN
    task automatic test_fast_mul();
        run_and_check("fast_mult_6x7",  ALU_MULT, 32'd6, 32'd7);
        run_and_check("fast_mult_neg",  ALU_MULT, 32'hFFFF_FFFA, 32'd7);
        run_and_check("fast_div_still", ALU_DIV,  32'd42, 32'd6);
    endtask
`endif

    initial begin
        id_ex_alu_op = ALU_NOP;
        id_ex_gpr_rs = '0;
        id_ex_gpr_rt = '0;
        reset        = 1'b0;
        @(negedge clk);
        test_reset();
        test_mul();
        test_div();
        test_mt_mf();
        test_reset_mid_busy();
        test_back_to_back();
`ifdef MULDIV_FAST_MUL_EN
        test_fast_mul();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
